// File: rtl/apb_rr_master_pkg.sv
// Shared FSM state type and default bus widths for the APB round-robin master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

endpackage

// File: rtl/apb_rr_master_if.sv
// APB4 bus bundle between the round-robin master and its completer.
interface apb_rr_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
);

    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_rr_master_arb.sv
// Round-robin picker: first asserted request at or after last_grant+1, wrapping.
module apb_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDXW-1:0]    index,
    output logic               any
);

    logic [IDXW-1:0] cand;

    always_comb begin
        gnt   = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDXW'((32'(last_grant) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                index     = cand;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// APB4 master that serves NUM_REQ requesters round-robin, with a per-transfer
// wait-state timeout that forces an error completion.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [NUM_REQ-1:0]              rsp_done,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    apb_rr_master_if.master                 apb
);

    localparam int IDXW  = $clog2(NUM_REQ);
    localparam int STRBW = DATA_WIDTH / 8;

    state_t                  state, state_nx;
    logic [IDXW-1:0]         last_grant, owner, win_idx;
    logic [NUM_REQ-1:0]      win_gnt;
    logic                    win_any, arb_en, capture, complete, timeout;
    logic [7:0]              wait_cnt;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRBW-1:0]        pstrb_q;

    apb_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (win_gnt),
        .index      (win_idx),
        .any        (win_any)
    );

    always_comb begin
        state_nx = state;
        arb_en   = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                arb_en = 1'b1;
                if (win_any) state_nx = SETUP;
            end
            SETUP: state_nx = ACCESS;
            ACCESS: begin
                if (apb.PREADY) begin
                    complete = 1'b1;
                    arb_en   = 1'b1;
                    state_nx = win_any ? SETUP : IDLE;
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // no grant (and so no ack) can be issued while reset is held
        capture = arb_en && win_any && PRESETn;
        req_ack = capture ? win_gnt : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant <= IDXW'(NUM_REQ - 1);
            owner      <= '0;
            wait_cnt   <= '0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            rsp_done   <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_done  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (complete || timeout) begin
                rsp_done[owner] <= 1'b1;
                rsp_err         <= timeout || apb.PSLVERR;
                if (complete && !pwrite_q) rsp_rdata <= apb.PRDATA;
            end

            if (capture) begin
                last_grant <= win_idx;
                owner      <= win_idx;
                pwrite_q   <= req_write[win_idx];
                paddr_q    <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                pwdata_q   <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                pstrb_q    <= req_write[win_idx] ? req_strb[win_idx*STRBW +: STRBW] : '0;
            end

            if (capture)                               wait_cnt <= '0;
            else if (state == ACCESS && !apb.PREADY)   wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign apb.PSEL    = (state != IDLE);
    assign apb.PENABLE = (state == ACCESS);
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;

endmodule

// File: doc/apb_rr_master.md
APB_RR_MASTER -- requirements
Module: apb_rr_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width; legal values are 8, 16 and 32.
REQ-003 Parameter NUM_REQ, default 4, number of requesters; legal range is 2..8.
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS cycles before forced termination; legal range is 1..255.
REQ-005 PCLK  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-006 PRESETn  in  1  reset, asynchronous and active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester transfer request.
REQ-008 req_write  in  NUM_REQ  per-requester direction; 1 = write.
REQ-009 req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-requester address.
REQ-010 req_wdata  in  NUM_REQ*DATA_WIDTH  packed per-requester write data.
REQ-011 req_strb  in  NUM_REQ*DATA_WIDTH/8  packed per-requester byte strobes.
REQ-012 req_ack  out  NUM_REQ  one-hot, one-cycle pulse: request captured.
REQ-013 rsp_done  out  NUM_REQ  one-hot, one-cycle pulse: transfer complete.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; valid while rsp_done is nonzero.
REQ-015 rsp_err  out  1  error flag; valid while rsp_done is nonzero.
REQ-016 PSEL, PENABLE, PWRITE  out  1 each  APB4 master controls.
REQ-017 PADDR  out  ADDR_WIDTH;  PWDATA  out  DATA_WIDTH;  PSTRB  out  DATA_WIDTH/8.
REQ-018 PRDATA  in  DATA_WIDTH;  PREADY  in  1;  PSLVERR  in  1.

Function
REQ-019 The FSM SHALL have three states, IDLE, SETUP and ACCESS, and SHALL drive PSEL=0/PENABLE=0 in IDLE, 1/0 in SETUP and 1/1 in ACCESS.
REQ-020 Arbitration SHALL occur in IDLE, and in ACCESS on the cycle PREADY=1, among asserted req_valid bits.
REQ-021 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, and last_grant resets to NUM_REQ-1.
REQ-022 At arbitration the winner's write, addr, wdata and strb SHALL be registered, and req_ack[winner] SHALL pulse in that same cycle.
REQ-023 The next state after arbitration SHALL be SETUP; the requester may change or drop its inputs after req_ack.
REQ-024 PADDR, PWRITE, PWDATA and PSTRB SHALL come from the capture registers and SHALL stay stable from SETUP through the final ACCESS cycle.
REQ-025 PSTRB SHALL be all-zero for reads regardless of req_strb.
REQ-026 SETUP SHALL always be followed by ACCESS after exactly one cycle.
REQ-027 In ACCESS with PREADY=0, the controller SHALL remain in ACCESS and increment an 8-bit wait counter.
REQ-028 In ACCESS with PREADY=1, the controller SHALL sample PRDATA and PSLVERR and go to SETUP if a request won arbitration, else to IDLE.
REQ-029 On the cycle after completion, rsp_done[owner] SHALL be 1, rsp_rdata SHALL hold the sampled PRDATA (0 for writes) and rsp_err SHALL hold PSLVERR.
REQ-030 If the wait counter reaches TIMEOUT-1 with PREADY still 0, the transfer SHALL end with rsp_err=1 and rsp_rdata=0, and the FSM SHALL go to IDLE.
REQ-031 The wait counter SHALL clear on every entry to SETUP.
REQ-032 Minimum latency SHALL be: req_valid sampled in IDLE at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_done at cycle 3.
REQ-033 Back-to-back throughput with zero wait states SHALL be one transfer per 2 cycles.
REQ-034 A requester that is still asserting req_valid when its own rsp_done pulses SHALL be treated as a new request.
REQ-035 With all req_valid bits low, the bus SHALL stay in IDLE and PADDR/PWDATA SHALL hold their last values.

Reset
REQ-036 On PRESETn=0, regardless of the clock, the block SHALL set state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA, PSTRB=0; req_ack, rsp_done, rsp_rdata, rsp_err=0; wait counter=0; last_grant=NUM_REQ-1.
REQ-037 A transfer in flight at reset SHALL be abandoned with no rsp_done.
REQ-038 The first arbitration after reset release SHALL occur no earlier than the first PCLK rising edge with PRESETn=1.

Structure
REQ-039 Package apb_pkg SHALL hold the state_t enum (IDLE, SETUP, ACCESS) and the default width constants ADDR_W=32 and DATA_W=32.
REQ-040 Round-robin selection SHALL live in sub-module apb_rr_arb (inputs req and last_grant; outputs one-hot gnt, index and any).
REQ-041 Capture registers, the FSM and the timeout counter SHALL live in apb_rr_master.

Verification
REQ-042 Single write: req_valid[2]=1, addr 0x10, wdata 0xA5A5_0001, strb 0xF, PREADY=1 -> req_ack[2] at cycle 0, SETUP at 1, ACCESS at 2, rsp_done[2]=1 with rsp_err=0 at 3.
REQ-043 Read with 3 wait states: PRDATA=0xDEADBEEF, PREADY high on the 4th ACCESS cycle -> PSTRB=0, rsp_rdata=0xDEADBEEF, PENABLE high for exactly 4 cycles.
REQ-044 All 4 requesters held valid from reset -> grants in order 0,1,2,3,0 and an ACCESS→SETUP transition each time with no IDLE gap.
REQ-045 PSLVERR=1 with PREADY=1 on a write -> rsp_err=1, and the next transfer proceeds normally.
REQ-046 PREADY held at 0 with TIMEOUT=16 -> after 16 ACCESS cycles, rsp_done is asserted with rsp_err=1, and PSEL=0 on the following cycle.
REQ-047 PRESETn asserted mid-ACCESS -> PSEL/PENABLE drop asynchronously, no rsp_done is issued, and the next grant after release goes to requester 0.
